onehot_dispatch: RTL
====================

# onehot_dispatch

Sequential counterpart to the binary/priority encoders and arbiters: accepts binary target indices over a valid/ready handshake and buffers them in a small FIFO. Each index is decoded to a one-hot request that is held until the addressed target acknowledges or a timeout expires. It sits between a command source that produces encoded indices and a bank of one-hot-selected targets. It handles one request at a time, strictly in arrival order.

## Interface
Parameters:
- n, 3, index width
- m, 8, number of targets / one-hot width (m <= 2^n)
- DEPTH, 4, FIFO entries (power of two, >= 2)
- TIMEOUT, 15, max cycles a request is held without ack (>= 1)

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous active-low reset
- in_valid  input  1  index offered
- in_ready  output  1  FIFO can accept
- in_idx  input  n  binary target index
- req  output  m  one-hot request, registered
- ack  input  m  per-target acknowledge
- busy  output  1  request outstanding
- count  output  ceil(log2(DEPTH+1))  FIFO occupancy
- err  output  1  one-cycle error pulse
- err_idx  output  n  index of the last errored request

## Operation
- Push occurs when in_valid && in_ready at a rising edge. in_ready = (count < DEPTH) && reset; it is low while reset is low.
- No bypass: when full, in_ready is low even if a pop happens in the same cycle.
- FSM has two states, IDLE and REQ. busy = (state == REQ).
- IDLE:
  - FIFO non-empty: pop head into cur_idx.
  - In-range index: load req = 1<<cur_idx, clear timer, go to REQ.
  - Out-of-range index (>= m): pulse err, set err_idx = cur_idx, keep req = 0, stay IDLE.
- REQ:
  - Only ack[cur_idx] is examined; other ack bits are ignored.
  - ack[cur_idx] high: request completes. If the FIFO is non-empty, pop the next entry and handle it as in IDLE in the same edge; otherwise req <= 0 and go to IDLE.
  - No ack with timer == TIMEOUT-1: abort. Pulse err, set err_idx = cur_idx, req <= 0, go to IDLE.
  - Otherwise timer increments.
- Ack arriving on the timeout edge wins: the request completes normally with no err.
- Simultaneous push and pop: count is unchanged, and the pushed entry is queued behind all existing entries.
- count changes by +1 (push only), -1 (pop only) or 0; it is never > DEPTH or < 0.
- FIFO pointers wrap modulo DEPTH.
- err_idx holds its value until the next error.

## Timing
- Reset, when reset is low at a rising edge:
  - state = IDLE; FIFO emptied; count = 0.
  - req = 0, busy = 0, err = 0, err_idx = 0, timer = 0.
- Reset mid-request drops req on that edge, with no err pulse and no queued entries retained.
- Latency from a push into an empty, idle block: pushed at edge E0, popped at E1, req visible after E1 (one cycle).
- ack[cur_idx] sampled high at edge E: req clears or switches after E. Back-to-back requests have no idle gap; req moves directly from one one-hot value to the next.
- Un-acked request: req is high for exactly TIMEOUT cycles, and err is high for the single cycle after the abort edge.
- All outputs are registered except in_ready, which is combinational from count and reset.

## Test plan
- Reset: hold reset low 3 cycles with in_valid=1, in_idx=3 -> req=0, busy=0, count=0, in_ready=0 throughout. After release, in_ready=1 and nothing is queued.
- Single dispatch: push idx=5 at E0 -> req=8'b0010_0000 from E1. Drive ack=8'b0010_0000 at E4 -> req=0 and busy=0 after E4, err never asserts.
- Wrong ack and timeout: push idx=2, hold ack=8'b0000_1000 -> req=8'b0000_0100 for exactly 15 cycles, then err pulses 1 cycle with err_idx=2 and busy=0.
- Fill and drain: ack=0, push indices 1,2,3,4,6,7 every cycle:
  - idx 1 is popped; count reaches 4; in_ready drops; idx 7 is stalled.
  - Then ack all ones -> req sequence 8'h02, 8'h04, 8'h08, 8'h10, 8'h40 on consecutive cycles, followed by idx 7 once in_ready rises.
- Timeout race: idx=0 un-acked, ack[0] high on the edge where timer == 14 -> normal completion, err stays 0.
- Out-of-range (n=3, m=6): push idx=7 -> req stays 0, err pulses one cycle after the pop edge, err_idx=7, and the next queued idx=1 yields req=6'b000010.

Source files
------------

// File: rtl/onehot_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dispatch_if
// Purpose  : Bundle for onehot_dispatch. Carries the index handshake from the
//            command source, the one-hot request / acknowledge pair toward the
//            target bank, and the status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface onehot_dispatch_if #(
  parameter int n     = 3,
  parameter int m     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [n-1:0]  in_idx;
  logic [m-1:0]  req;
  logic [m-1:0]  ack;
  logic          busy;
  logic [CW-1:0] count;
  logic          err;
  logic [n-1:0]  err_idx;

  // Command source / target bank side
  modport master (
    output in_valid, in_idx, ack,
    input  in_ready, req, busy, count, err, err_idx
  );

  // Dispatcher side
  modport slave (
    input  in_valid, in_idx, ack,
    output in_ready, req, busy, count, err, err_idx
  );
endinterface
`default_nettype wire

// File: rtl/onehot_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dispatch
// Purpose  : Queues binary target indices in a small FIFO and presents each
//            one, in arrival order, as a registered one-hot request held until
//            the addressed target acknowledges or a timeout expires.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_dispatch #(
  parameter int n       = 3,
  parameter int m       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  wire logic          clk,
  input  wire logic          reset,
  onehot_dispatch_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [n-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;

  // Request engine state
  state_t        state_r;
  state_t        state_n;
  logic [m-1:0]  req_r;
  logic [m-1:0]  req_n;
  logic [n-1:0]  cur_r;
  logic [n-1:0]  cur_n;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_n;
  logic          err_r;
  logic          err_n;
  logic [n-1:0]  err_idx_r;
  logic [n-1:0]  err_idx_n;

  logic          in_ready;
  logic          push;
  logic          pop;
  logic          empty;
  logic [n-1:0]  head;
  logic [m-1:0]  dec;
  logic          in_range;
  logic          ack_hit;

  // No bypass: a full FIFO refuses even if a pop happens this cycle
  assign in_ready = (count_r < CW'(DEPTH)) && reset;
  assign push     = bus.in_valid && in_ready;
  assign empty    = (count_r == '0);
  assign head     = mem[rptr_r];

  // Decode the head index; an index with no matching target leaves dec all-zero
  for (genvar j = 0; j < m; j++) begin : g_dec
    assign dec[j] = (head == n'(j));
  end
  assign in_range = |dec;

  // req is one-hot at cur_idx while in REQ, so masking ack with it looks
  // only at the addressed target's acknowledge
  assign ack_hit = |(bus.ack & req_r);

  // FIFO payload write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_r] <= bus.in_idx;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Request engine state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      req_r     <= '0;
      cur_r     <= '0;
      timer_r   <= '0;
      err_r     <= 1'b0;
      err_idx_r <= '0;
    end else begin
      state_r   <= state_n;
      req_r     <= req_n;
      cur_r     <= cur_n;
      timer_r   <= timer_n;
      err_r     <= err_n;
      err_idx_r <= err_idx_n;
    end
  end

  // Next-state: completion, timeout, and loading of the next queued index
  always_comb begin
    state_n   = state_r;
    req_n     = req_r;
    cur_n     = cur_r;
    timer_n   = timer_r;
    err_n     = 1'b0;
    err_idx_n = err_idx_r;
    pop       = 1'b0;

    case (state_r)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      REQ: begin
        // An ack on the timeout edge takes priority over the abort
        if (ack_hit) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            req_n   = '0;
            state_n = IDLE;
          end
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          err_n     = 1'b1;
          err_idx_n = cur_r;
          req_n     = '0;
          state_n   = IDLE;
        end else begin
          timer_n = timer_r + TW'(1);
        end
      end
      default: begin
        req_n   = '0;
        state_n = IDLE;
      end
    endcase

    // Shared by IDLE and by a completing REQ so back-to-back requests
    // switch directly from one one-hot value to the next
    if (pop) begin
      cur_n = head;
      if (in_range) begin
        req_n   = dec;
        timer_n = '0;
        state_n = REQ;
      end else begin
        err_n     = 1'b1;
        err_idx_n = head;
        req_n     = '0;
        state_n   = IDLE;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.req      = req_r;
  assign bus.busy     = (state_r == REQ);
  assign bus.count    = count_r;
  assign bus.err      = err_r;
  assign bus.err_idx  = err_idx_r;

endmodule
`default_nettype wire
